// File: rtl/alu_issue_ctrl.sv
// Execute-stage sequencer in front of the ALU: issues one op at a time, waits out the
// multi-cycle divider, and hands the result to register-file writeback via valid/ready.
module alu_issue_ctrl #(
   parameter int unsigned RD_W   = 3,
   parameter int unsigned CNT_W  = 16,
   parameter logic [3:0]  OP_DIV = 4'd3,
   parameter logic [3:0]  OP_MOD = 4'd4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       in_op,
   input  logic [RD_W-1:0]  in_rd,
   input  logic [15:0]      in_ra,
   input  logic [15:0]      in_rb,
   output logic             alu_enable,
   output logic [3:0]       alu_op,
   output logic [15:0]      alu_ra,
   output logic [15:0]      alu_rb,
   input  logic [15:0]      alu_out,
   input  logic             alu_busy,
   output logic             wb_valid,
   input  logic             wb_ready,
   output logic [RD_W-1:0]  wb_rd,
   output logic [15:0]      wb_data,
   output logic [2:0]       flags,
   output logic [CNT_W-1:0] div_stall_cnt
);

   localparam logic [3:0] OP_XXX = 4'd14;
   localparam logic [3:0] OP_CMP = 4'd15;

   typedef enum logic [2:0] {StIdle, StIssue, StResult, StDivWait, StWb} state_e;

   state_e           state_q, state_d;
   logic [3:0]       op_q;
   logic [RD_W-1:0]  rd_q;
   logic [15:0]      ra_q, rb_q;
   logic [15:0]      wb_data_q;
   logic [2:0]       flags_q;
   logic [CNT_W-1:0] cnt_q;
   logic             seen_busy_q;
   logic             op_is_div;
   logic             div_done;

   assign op_is_div = (op_q == OP_DIV) || (op_q == OP_MOD);
   // Busy must have been observed first so a late-starting divider is not mistaken for done.
   assign div_done  = seen_busy_q && !alu_busy;

   always_comb begin
      state_d    = state_q;
      in_ready   = 1'b0;
      alu_enable = 1'b0;
      alu_op     = OP_XXX;
      wb_valid   = 1'b0;
      case (state_q)
         StIdle: begin
            in_ready = 1'b1;
            if (in_valid) state_d = StIssue;
         end
         StIssue: begin
            alu_op = op_q;
            if (op_q == OP_XXX) begin
               state_d = StIdle;
            end else if (op_is_div) begin
               state_d = StDivWait;
            end else begin
               alu_enable = 1'b1;
               state_d    = StResult;
            end
         end
         StResult: state_d = StWb;
         StDivWait: begin
            // Holding the div op keeps the divider's result on alu_out until capture.
            alu_op = op_q;
            if (div_done) state_d = StWb;
         end
         StWb: begin
            wb_valid = 1'b1;
            if (wb_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StIdle;
         op_q        <= '0;
         rd_q        <= '0;
         ra_q        <= '0;
         rb_q        <= '0;
         wb_data_q   <= '0;
         flags_q     <= '0;
         cnt_q       <= '0;
         seen_busy_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (state_q == StIdle && in_valid) begin
            op_q <= in_op;
            rd_q <= in_rd;
            ra_q <= in_ra;
            rb_q <= in_rb;
         end
         if (state_q == StIssue) seen_busy_q <= 1'b0;
         if (state_q == StResult) begin
            wb_data_q <= alu_out;
            if (op_q == OP_CMP) flags_q <= alu_out[2:0];
         end
         if (state_q == StDivWait) begin
            if (alu_busy) seen_busy_q <= 1'b1;
            if (div_done) wb_data_q <= alu_out;
            if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
         end
      end
   end

   assign alu_ra        = ra_q;
   assign alu_rb        = rb_q;
   assign wb_rd         = rd_q;
   assign wb_data       = wb_data_q;
   assign flags         = flags_q;
   assign div_stall_cnt = cnt_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: a behavioural ALU/divider stand-in plus a transaction-level
// reference model of latency, writeback data, compare flags and stall count.
module tb_alu_issue_ctrl;
   localparam int unsigned RD_W  = 3;
   localparam int unsigned CNT_W = 16;
   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_SUB = 4'd1;
   localparam logic [3:0] OP_DIV = 4'd3;
   localparam logic [3:0] OP_MOD = 4'd4;
   localparam logic [3:0] OP_XXX = 4'd14;
   localparam logic [3:0] OP_CMP = 4'd15;

   logic             clk = 1'b0;
   logic             reset;
   logic             in_valid, in_ready;
   logic [3:0]       in_op;
   logic [RD_W-1:0]  in_rd;
   logic [15:0]      in_ra, in_rb;
   logic             alu_enable;
   logic [3:0]       alu_op;
   logic [15:0]      alu_ra, alu_rb, alu_out;
   logic             alu_busy;
   logic             wb_valid, wb_ready;
   logic [RD_W-1:0]  wb_rd;
   logic [15:0]      wb_data;
   logic [2:0]       flags;
   logic [CNT_W-1:0] div_stall_cnt;

   int          vectors = 0;
   int          errors  = 0;
   logic [2:0]  m_flags = 3'b000;
   int unsigned m_cnt   = 0;

   alu_issue_ctrl #(
      .RD_W  (RD_W),
      .CNT_W (CNT_W),
      .OP_DIV(OP_DIV),
      .OP_MOD(OP_MOD)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_op        (in_op),
      .in_rd        (in_rd),
      .in_ra        (in_ra),
      .in_rb        (in_rb),
      .alu_enable   (alu_enable),
      .alu_op       (alu_op),
      .alu_ra       (alu_ra),
      .alu_rb       (alu_rb),
      .alu_out      (alu_out),
      .alu_busy     (alu_busy),
      .wb_valid     (wb_valid),
      .wb_ready     (wb_ready),
      .wb_rd        (wb_rd),
      .wb_data      (wb_data),
      .flags        (flags),
      .div_stall_cnt(div_stall_cnt)
   );

   always #5 clk = ~clk;

   function automatic logic is_div(input logic [3:0] op);
      return (op == OP_DIV) || (op == OP_MOD);
   endfunction

   function automatic logic [15:0] alu_fn(input logic [3:0] op, input logic [15:0] a,
                                          input logic [15:0] b);
      case (op)
         4'd0:  return a + b;
         4'd1:  return a - b;
         4'd2:  return a * b;
         4'd3:  return (b == 16'd0) ? 16'hFFFF : a / b;
         4'd4:  return (b == 16'd0) ? a : a % b;
         4'd5:  return a & b;
         4'd6:  return a | b;
         4'd7:  return a ^ b;
         4'd8:  return ~a;
         4'd9:  return a << b[3:0];
         4'd10: return a >> b[3:0];
         4'd11: return {a[7:0], a[15:8]};
         4'd12: return a + 16'd1;
         4'd13: return a - 16'd1;
         4'd15: return {13'd0, a > b, a == b, a < b};
         default: return 16'h0000;
      endcase
   endfunction

   // ALU stand-in: registered result for simple ops, 16-cycle divider started by a div op.
   logic [15:0] alu_res_q;
   int          div_left;
   logic        div_fin;

   always @(posedge clk) begin
      if (reset) begin
         alu_res_q <= 16'h0;
         div_left  <= 0;
         div_fin   <= 1'b0;
      end else begin
         if (alu_enable) alu_res_q <= alu_fn(alu_op, alu_ra, alu_rb);
         if (is_div(alu_op)) begin
            if (div_left == 0 && !div_fin) begin
               div_left <= 16;
            end else if (div_left > 0) begin
               div_left <= div_left - 1;
               if (div_left == 1) div_fin <= 1'b1;
            end
         end else begin
            div_fin <= 1'b0;
         end
      end
   end

   assign alu_busy = (div_left != 0);
   assign alu_out  = is_div(alu_op) ? alu_fn(alu_op, alu_ra, alu_rb) : alu_res_q;

   task automatic run_op(input logic [3:0] op, input logic [RD_W-1:0] rd, input logic [15:0] ra,
                         input logic [15:0] rb, input int hold);
      int          cyc;
      int          exp_lat;
      logic [15:0] exp_data;
      exp_lat  = is_div(op) ? 19 : 3;
      exp_data = alu_fn(op, ra, rb);
      cyc = 0;
      while (in_ready !== 1'b1 && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      vectors++;
      if (in_ready !== 1'b1) $display("FAIL idle_wait: in_ready=%b want 1", in_ready);
      in_valid = 1'b1;
      in_op    = op;
      in_rd    = rd;
      in_ra    = ra;
      in_rb    = rb;
      wb_ready = (hold == 0);
      @(negedge clk);
      // Junk on the input bus must be ignored while busy.
      in_valid = 1'b0;
      in_op    = 4'($urandom);
      in_ra    = 16'($urandom);
      in_rb    = 16'($urandom);
      cyc = 1;
      vectors++;
      if (alu_op !== op) begin
         errors++;
         $display("FAIL issue_alu_op: got %h want %h", alu_op, op);
      end
      vectors++;
      if (alu_enable !== (op != OP_XXX && !is_div(op))) begin
         errors++;
         $display("FAIL issue_alu_enable: got %b for op %h", alu_enable, op);
      end
      if (op == OP_XXX) begin
         vectors++;
         if (in_ready !== 1'b0 || wb_valid !== 1'b0) begin
            errors++;
            $display("FAIL xxx_c1: in_ready=%b wb_valid=%b want 0 0", in_ready, wb_valid);
         end
         @(negedge clk);
         vectors++;
         if (in_ready !== 1'b1 || wb_valid !== 1'b0) begin
            errors++;
            $display("FAIL xxx_c2: in_ready=%b wb_valid=%b want 1 0", in_ready, wb_valid);
         end
      end else begin
         while (wb_valid !== 1'b1 && cyc < 40) begin
            vectors++;
            if (in_ready !== 1'b0) begin
               errors++;
               $display("FAIL busy_in_ready: cycle %0d in_ready=%b want 0", cyc, in_ready);
            end
            @(negedge clk);
            cyc++;
         end
         if (is_div(op)) m_cnt = (m_cnt + 17 > 65535) ? 65535 : m_cnt + 17;
         if (op == OP_CMP) m_flags = exp_data[2:0];
         vectors++;
         if (cyc != exp_lat) begin
            errors++;
            $display("FAIL latency: op %h wb_valid at cycle %0d want %0d", op, cyc, exp_lat);
         end
         vectors++;
         if (wb_rd !== rd || wb_data !== exp_data) begin
            errors++;
            $display("FAIL wb_payload: op %h got rd=%0d data=%h want rd=%0d data=%h",
                     op, wb_rd, wb_data, rd, exp_data);
         end
         for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            vectors++;
            if (wb_valid !== 1'b1 || wb_data !== exp_data || wb_rd !== rd || in_ready !== 1'b0)
            begin
               errors++;
               $display("FAIL wb_hold: valid=%b data=%h rd=%0d in_ready=%b want 1 %h %0d 0",
                        wb_valid, wb_data, wb_rd, in_ready, exp_data, rd);
            end
         end
         wb_ready = 1'b1;
         @(negedge clk);
         vectors++;
         if (in_ready !== 1'b1 || wb_valid !== 1'b0) begin
            errors++;
            $display("FAIL post_wb: in_ready=%b wb_valid=%b want 1 0", in_ready, wb_valid);
         end
      end
      vectors++;
      if (flags !== m_flags || div_stall_cnt !== CNT_W'(m_cnt)) begin
         errors++;
         $display("FAIL sticky_state: flags=%b cnt=%0d want %b %0d",
                  flags, div_stall_cnt, m_flags, m_cnt);
      end
   endtask

   task automatic check_reset_values(input string tag);
      vectors++;
      if (in_ready !== 1'b1 || wb_valid !== 1'b0 || alu_enable !== 1'b0 || alu_op !== OP_XXX ||
          wb_data !== 16'h0 || wb_rd !== '0 || flags !== 3'b000 || div_stall_cnt !== '0 ||
          alu_ra !== 16'h0 || alu_rb !== 16'h0) begin
         errors++;
         $display("FAIL %s: rdy=%b wbv=%b en=%b op=%h data=%h rd=%0d fl=%b cnt=%0d ra=%h rb=%h",
                  tag, in_ready, wb_valid, alu_enable, alu_op, wb_data, wb_rd, flags,
                  div_stall_cnt, alu_ra, alu_rb);
      end
   endtask

   task automatic test_reset;
      reset    = 1'b1;
      in_valid = 1'b0;
      in_op    = 4'h0;
      in_rd    = '0;
      in_ra    = 16'h0;
      in_rb    = 16'h0;
      wb_ready = 1'b1;
      repeat (3) @(negedge clk);
      reset   = 1'b0;
      m_flags = 3'b000;
      m_cnt   = 0;
      check_reset_values("reset_state");
   endtask

   task automatic test_add;
      run_op(OP_ADD, 3'd2, 16'h1234, 16'h0001, 0);
   endtask

   task automatic test_div_mod;
      run_op(OP_DIV, 3'd5, 16'd100, 16'd7, 0);
      run_op(OP_MOD, 3'd6, 16'd100, 16'd7, 0);
   endtask

   task automatic test_cmp;
      run_op(OP_CMP, 3'd1, 16'd5, 16'd9, 0);
      run_op(OP_CMP, 3'd1, 16'd9, 16'd5, 0);
      run_op(OP_CMP, 3'd4, 16'd7, 16'd7, 1);
   endtask

   task automatic test_xxx;
      run_op(OP_XXX, 3'd7, 16'hAAAA, 16'h5555, 0);
   endtask

   task automatic test_sub_hold;
      run_op(OP_SUB, 3'd3, 16'h0000, 16'h0001, 5);
   endtask

   task automatic test_div_zero;
      run_op(OP_DIV, 3'd2, 16'h1357, 16'h0000, 0);
      run_op(OP_MOD, 3'd2, 16'h1357, 16'h0000, 2);
   endtask

   task automatic test_reset_mid_div;
      int seen_wb;
      in_valid = 1'b1;
      in_op    = OP_DIV;
      in_rd    = 3'd4;
      in_ra    = 16'd1000;
      in_rb    = 16'd3;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (7) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset   = 1'b0;
      m_flags = 3'b000;
      m_cnt   = 0;
      check_reset_values("reset_mid_div");
      seen_wb = 0;
      for (int i = 0; i < 25; i++) begin
         @(negedge clk);
         if (wb_valid === 1'b1) seen_wb++;
      end
      vectors++;
      if (seen_wb != 0) begin
         errors++;
         $display("FAIL abort_no_wb: wb_valid seen %0d cycles want 0", seen_wb);
      end
      run_op(OP_ADD, 3'd1, 16'h00FF, 16'h0101, 0);
   endtask

   task automatic test_random;
      logic [3:0] op;
      for (int n = 0; n < 40; n++) begin
         op = 4'($urandom_range(0, 15));
         run_op(op, RD_W'($urandom), 16'($urandom), 16'($urandom_range(0, 3) == 0 ? 0 : $urandom),
                int'($urandom_range(0, 3)));
      end
   endtask

   initial begin
      test_reset();
      test_add();
      test_div_mod();
      test_cmp();
      test_xxx();
      test_sub_hold();
      test_div_zero();
      test_reset_mid_div();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
